// File: rtl/des_sbox_engine.sv
// Iterative DES S-box substitution: eight 6->4 lookups on a 48-bit word, LANES per clock,
// producing the 32-bit pre-P-permutation result behind valid/ready handshakes.
module des_sbox_engine #(
    parameter int LANES    = 2,
    parameter bit OUT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int PASSES = 8 / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    // S1..S8 from MSB down; within a box, entry (row*16+col) is nibble number row*16+col from the left.
    localparam logic [2047:0] SBOX_ROM = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input int s, input logic [5:0] b);
        int idx;
        idx = int'({b[5], b[0], b[4:1]});
        return SBOX_ROM[2047 - s*256 - idx*4 -: 4];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [47:0]   hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_q, res_d;
    logic          rdy_q;

    assign in_ready  = rdy_q && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_SUB) || (state_q == S_DONE);
    assign out_data  = res_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    hold_d  = in_data;
                    cnt_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                for (int i = 0; i < LANES; i++) begin
                    int sidx;
                    sidx = int'(cnt_q) * LANES + i;
                    res_d[31 - 4*sidx -: 4] = sbox_lookup(sidx, hold_q[47 - 6*sidx -: 6]);
                end
                // Counter parks on the last pass rather than wrapping.
                if (cnt_q == CW'(PASSES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (!OUT_HOLD) begin
                        res_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Directed bench for des_sbox_engine: four instances (LANES=1,2,4,8; the LANES=8 one with
// OUT_HOLD=0) checked against hand-computed vectors and an independent table model.
module tb_des_sbox_engine;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [3:0]  busy;
    logic [47:0] in_data  [4];
    logic [31:0] out_data [4];

    int checks;
    int failures;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_engine #(
            .LANES   (1 << g),
            .OUT_HOLD((g == 3) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] ref_sub(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  b;
        int row, col;
        r = '0;
        for (int s = 0; s < 8; s++) begin
            b   = d[47 - 6*s -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            r[31 - 4*s -: 4] = 4'(SB[s][row*16 + col]);
        end
        return r;
    endfunction

    // Offers one word to instance k and returns once out_valid is seen (or a bound expires).
    // lat counts clock edges from the accept edge inclusive up to the edge that raised out_valid.
    task automatic run_word(input int k, input logic [47:0] d, input bit do_ready,
                            output logic [31:0] res, output int lat, output bit ok);
        int guard;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        guard = 0;
        while (!in_ready[k] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = in_ready[k];
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
        lat = 1;
        while (!out_valid[k] && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok  = ok && out_valid[k];
        res = out_data[k];
        if (do_ready) begin
            out_ready[k] = 1'b1;
            @(posedge clk);
            #1 out_ready[k] = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || out_data[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: in_ready=%b out_valid=%b busy=%b out_data=%h, required 0/0/0/00000000",
                         k, in_ready[k], out_valid[k], busy[k], out_data[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b before first clock, required 0000", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 4'b1111) begin
            failures++;
            $display("FAIL reset_first_clock_ready: in_ready=%b, required 1111", in_ready);
        end
    endtask

    task automatic test_zero;
        logic [31:0] r;
        int lat;
        bit ok;
        run_word(1, 48'h0, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== 32'hEFA72C4D) begin
            failures++;
            $display("FAIL zero_word: out_data=%h ok=%b, required EFA72C4D", r, ok);
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL zero_latency: got %0d, required 5", lat);
        end
        checks++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL zero_after_handshake: out_valid=%b in_ready=%b busy=%b, required 0/1/0",
                     out_valid[1], in_ready[1], busy[1]);
        end
    endtask

    task automatic test_ones;
        logic [31:0] r;
        int lat;
        bit ok;
        run_word(1, 48'hFFFF_FFFF_FFFF, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== 32'hD9CE3DCB) begin
            failures++;
            $display("FAIL ones_word: out_data=%h ok=%b, required D9CE3DCB", r, ok);
        end
    endtask

    task automatic test_s3_row;
        logic [31:0] r;
        int lat;
        bit ok;
        run_word(1, 48'h0000_4000_0000, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== 32'hEFD72C4D) begin
            failures++;
            $display("FAIL s3_row1: out_data=%h ok=%b, required EFD72C4D", r, ok);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r;
        int lat;
        bit ok;
        run_word(1, 48'hFFFF_FFFF_FFFF, 1'b0, r, lat, ok);
        checks++;
        if (!ok || r !== 32'hD9CE3DCB) begin
            failures++;
            $display("FAIL bp_result: out_data=%h ok=%b, required D9CE3DCB", r, ok);
        end
        in_valid[1] = 1'b1;
        in_data[1]  = 48'h0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== 32'hD9CE3DCB || in_ready[1] !== 1'b0 || busy[1] !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b out_data=%h in_ready=%b busy=%b, required 1/D9CE3DCB/0/1",
                         c, out_valid[1], out_data[1], in_ready[1], busy[1]);
            end
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1 out_ready[1] = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || out_data[1] !== 32'hD9CE3DCB) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out_data=%h, required 0/1/D9CE3DCB",
                     out_valid[1], in_ready[1], out_data[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy[1] !== 1'b0 || out_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_extra_accept: busy=%b out_valid=%b, required 0/0", busy[1], out_valid[1]);
        end
    endtask

    task automatic test_reset_mid_sub;
        logic [31:0] r;
        int lat;
        bit ok;
        bit seen;
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1]  = 48'hFFFF_FFFF_FFFF;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_in_sub: busy=%b, required 1", busy[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy[1] !== 1'b0 || out_valid[1] !== 1'b0 || in_ready[1] !== 1'b0 || out_data[1] !== 32'h0) begin
            failures++;
            $display("FAIL midrst_async: busy=%b out_valid=%b in_ready=%b out_data=%h, required 0/0/0/00000000",
                     busy[1], out_valid[1], in_ready[1], out_data[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[1] || busy[1]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midrst_no_output: out_valid/busy rose after reset, required both to stay 0");
        end
        run_word(1, 48'h0, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== 32'hEFA72C4D || lat !== 5) begin
            failures++;
            $display("FAIL midrst_next_word: out_data=%h lat=%0d ok=%b, required EFA72C4D lat 5", r, lat, ok);
        end
    endtask

    task automatic test_out_hold0;
        logic [31:0] r;
        int lat;
        bit ok;
        run_word(3, 48'hFFFF_FFFF_FFFF, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== 32'hD9CE3DCB || lat !== 2) begin
            failures++;
            $display("FAIL hold0_result: out_data=%h lat=%0d ok=%b, required D9CE3DCB lat 2", r, lat, ok);
        end
        checks++;
        if (out_data[3] !== 32'h0 || out_valid[3] !== 1'b0) begin
            failures++;
            $display("FAIL hold0_cleared: out_data=%h out_valid=%b, required 00000000/0", out_data[3], out_valid[3]);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] w;
        logic [31:0] r;
        logic [31:0] exp_r;
        int lat;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 5; n++) begin
                w = {16'($urandom), 32'($urandom)};
                exp_r = ref_sub(w);
                run_word(k, w, 1'b1, r, lat, ok);
                checks++;
                if (!ok || r !== exp_r) begin
                    failures++;
                    $display("FAIL b2b_data lanes=%0d in=%h: out_data=%h ok=%b, required %h", 1 << k, w, r, ok, exp_r);
                end
                checks++;
                if (lat !== (8 >> k) + 1) begin
                    failures++;
                    $display("FAIL b2b_latency lanes=%0d: got %0d, required %0d", 1 << k, lat, (8 >> k) + 1);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 4; k++) in_data[k] = '0;
        test_reset();
        test_zero();
        test_ones();
        test_s3_row();
        test_backpressure();
        test_reset_mid_sub();
        test_out_hold0();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

endmodule
